// File: rtl/logic_seq_pkg.sv
// Shared types, default timing constants and the LED logic-function helper
// for the two-operand logic demo sequencer.
package logic_seq_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    STEP   = 2'b10
  } mode_t;

  localparam int unsigned DEF_TICK_CYCLES     = 100_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;

  // LED[3:0] pattern: {XOR, OR, AND, NOT a0}
  function automatic logic [3:0] logic_ops(input logic [1:0] a);
    return {a[1] ^ a[0], a[1] | a[0], a[1] & a[0], ~a[0]};
  endfunction

endpackage

// File: rtl/debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debounce and a
// one-cycle rising-edge press pulse.
module debounce
  import logic_seq_pkg::*;
#(
  parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(CYCLES);

  logic [1:0]       sync_q;
  logic [1:0]       vld_q,    vld_d;
  logic             stable_q, stable_d;
  logic             armed_q,  armed_d;
  logic             press_q,  press_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             level;

  assign level = sync_q[1];
  assign press = press_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b00;
      vld_q    <= 2'b00;
      stable_q <= 1'b0;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], din};
      vld_q    <= vld_d;
      stable_q <= stable_d;
      armed_q  <= armed_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // Arming needs a debounced release seen after the synchronizer has filled,
  // so a button held through reset cannot produce a press.
  always_comb begin
    vld_d    = {vld_q[0], 1'b1};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    press_d  = 1'b0;

    if (level == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
      stable_d = level;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if ((vld_q == 2'b11) && !level && !stable_q) begin
      armed_d = 1'b1;
    end

    press_d = armed_q & ~stable_q & stable_d;
  end

endmodule

// File: rtl/logic_sequencer.sv
// Top of the logic demo: picks the operand source (switches, auto counter or
// button-stepped counter) and drives the registered LED bank.
module logic_sequencer
  import logic_seq_pkg::*;
#(
  parameter int unsigned TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] SW,
  input  logic       BTNC,
  input  logic       BTNU,
  output logic [7:0] LED
);

  localparam int unsigned TICK_W = $clog2(TICK_CYCLES);

  logic [1:0]        sw_s1_q, sw_s2_q;
  logic              btnc_press, btnu_press;
  mode_t             mode_q,  mode_d;
  logic [1:0]        seq_q,   seq_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [7:0]        led_q,   led_d;
  logic [1:0]        operand;

  assign LED = led_q;

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_btnc (
    .clk   (clk),
    .rst   (rst),
    .din   (BTNC),
    .press (btnc_press)
  );

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_btnu (
    .clk   (clk),
    .rst   (rst),
    .din   (BTNU),
    .press (btnu_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= 2'b00;
      sw_s2_q <= 2'b00;
      mode_q  <= MANUAL;
      seq_q   <= 2'b00;
      tick_q  <= '0;
      led_q   <= 8'h00;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      mode_q  <= mode_d;
      seq_q   <= seq_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
    end
  end

  // Mode advance has priority over stepping; entering AUTO/STEP restarts seq.
  always_comb begin
    mode_d = mode_q;
    seq_d  = seq_q;
    tick_d = tick_q;

    case (mode_q)
      MANUAL: begin
        if (btnc_press) begin
          mode_d = AUTO;
          seq_d  = 2'b00;
          tick_d = '0;
        end
      end
      AUTO: begin
        if (btnc_press) begin
          mode_d = STEP;
          seq_d  = 2'b00;
          tick_d = '0;
        end else if (tick_q == TICK_W'(TICK_CYCLES - 1)) begin
          tick_d = '0;
          seq_d  = seq_q + 2'd1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      STEP: begin
        if (btnc_press) begin
          mode_d = MANUAL;
        end else if (btnu_press) begin
          seq_d = seq_q + 2'd1;
        end
      end
      default: mode_d = MANUAL;
    endcase
  end

  always_comb begin
    operand = (mode_q == MANUAL) ? sw_s2_q : seq_q;
    led_d   = {2'(mode_q), operand, logic_ops(operand)};
  end

endmodule

// File: tb/tb_logic_sequencer.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus
// literal expectations on the directed scenarios, then randomized traffic.
module tb_logic_sequencer;

  localparam int D = 4;
  localparam int T = 8;

  logic       clk;
  logic       rst;
  logic [1:0] SW;
  logic       BTNC, BTNU;
  logic [7:0] LED;

  int tests  = 0;
  int errors = 0;

  logic_sequencer #(.TICK_CYCLES(T), .DEBOUNCE_CYCLES(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .SW   (SW),
    .BTNC (BTNC),
    .BTNU (BTNU),
    .LED  (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [1:0] m_sw1, m_sw2;
  logic       b_p1[2], b_p2[2], b_stab[2], b_arm[2], b_press[2];
  int         b_run[2];
  int         warm;
  int         m_mode, m_seq, m_auto;
  logic [7:0] exp_led;
  bit         chk_en = 0;

  function automatic logic [7:0] led_of(input int mode, input int op);
    logic [3:0] f;
    f[0] = (op % 2) == 0;
    f[1] = (op == 3);
    f[2] = (op != 0);
    f[3] = (op == 1) || (op == 2);
    return {2'(mode), 2'(op), f};
  endfunction

  always @(posedge clk) begin
    int   op;
    logic pin[2];
    logic lvl, old_arm;
    if (rst) begin
      m_sw1 = 0; m_sw2 = 0; warm = 0;
      m_mode = 0; m_seq = 0; m_auto = 0;
      exp_led = 8'h00;
      for (int i = 0; i < 2; i++) begin
        b_p1[i] = 0; b_p2[i] = 0; b_stab[i] = 0;
        b_arm[i] = 0; b_press[i] = 0; b_run[i] = 0;
      end
      chk_en = 1;
    end else begin
      op = (m_mode == 0) ? int'(m_sw2) : m_seq;
      exp_led = led_of(m_mode, op);
      if (b_press[0]) begin
        m_mode = (m_mode + 1) % 3;
        if (m_mode != 0) begin m_seq = 0; m_auto = 0; end
      end else if (m_mode == 1) begin
        m_auto++;
        m_seq = (m_auto / T) % 4;
      end else if (m_mode == 2 && b_press[1]) begin
        m_seq = (m_seq + 1) % 4;
      end
      pin[0] = BTNC;
      pin[1] = BTNU;
      for (int i = 0; i < 2; i++) begin
        lvl = b_p2[i];
        old_arm = b_arm[i];
        b_press[i] = 0;
        if (warm >= 2 && !lvl && !b_stab[i]) b_arm[i] = 1;
        if (lvl != b_stab[i]) begin
          b_run[i]++;
          if (b_run[i] == D) begin
            b_stab[i] = lvl;
            b_run[i]  = 0;
            if (lvl && old_arm) b_press[i] = 1;
          end
        end else begin
          b_run[i] = 0;
        end
        b_p2[i] = b_p1[i];
        b_p1[i] = pin[i];
      end
      m_sw2 = m_sw1;
      m_sw1 = SW;
      if (warm < 2) warm++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (LED !== exp_led) begin
        errors++;
        $display("FAIL model_cmp t=%0t: LED=%02h expected %02h", $time, LED, exp_led);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [7:0] mask, input logic [7:0] exp);
    tests++;
    if ((LED & mask) !== exp) begin
      errors++;
      $display("FAIL %s: LED&%02h=%02h expected %02h", name, mask, LED & mask, exp);
    end
  endtask

  logic [7:0] man_tab[4];
  logic [7:0] prev;

  initial begin
    man_tab[0] = 8'h01; man_tab[1] = 8'h1C; man_tab[2] = 8'h2D; man_tab[3] = 8'h36;
    rst = 1; SW = 2'b11; BTNC = 0; BTNU = 0;
    cyc(3);
    lit("reset_led", 8'hFF, 8'h00);
    rst = 0;
    cyc(1);
    lit("first_after_reset", 8'hFF, 8'h01);
    cyc(2);
    lit("sw11_latency3", 8'hFF, 8'h36);

    // MANUAL sweep with latency pin
    prev = 8'h36;
    for (int v = 0; v < 4; v++) begin
      SW = 2'(v);
      cyc(2);
      lit("manual_before", 8'hFF, prev);
      cyc(1);
      lit("manual_after", 8'hFF, man_tab[v]);
      cyc(7);
      prev = man_tab[v];
    end

    // BTNC press -> AUTO, then auto stepping
    BTNC = 1;
    cyc(7);
    lit("auto_not_yet", 8'hFF, 8'h36);
    cyc(1);
    lit("auto_entry", 8'hFF, 8'h41);
    cyc(2);
    BTNC = 0;
    cyc(6);
    for (int k = 1; k <= 4; k++) begin
      lit("auto_step", 8'hFF, man_tab[k % 4] | 8'h40);
      cyc(8);
    end

    // glitches rejected, then clean press -> STEP
    for (int g = 1; g <= 3; g++) begin
      BTNC = 1; cyc(g);
      BTNC = 0; cyc(8);
    end
    lit("glitch_no_change", 8'hC0, 8'h40);
    BTNC = 1; cyc(10);
    BTNC = 0; cyc(10);
    lit("step_entry", 8'hFF, 8'h81);
    for (int p = 0; p < 3; p++) begin
      BTNU = 1; cyc(8);
      BTNU = 0; cyc(8);
    end
    lit("step_three", 8'hFF, 8'hB6);

    // simultaneous presses: mode wins
    BTNC = 1; BTNU = 1; cyc(10);
    BTNC = 0; BTNU = 0; cyc(10);
    lit("simul_manual", 8'hFF, 8'h36);
    BTNU = 1; cyc(8);
    BTNU = 0; cyc(8);
    lit("btnu_manual_ignored", 8'hFF, 8'h36);

    // reset mid-AUTO with BTNC held
    BTNC = 1; cyc(10);
    BTNC = 0; cyc(10);
    lit("auto_again", 8'hC0, 8'h40);
    BTNC = 1; cyc(3);
    rst = 1; cyc(2);
    lit("mid_reset", 8'hFF, 8'h00);
    rst = 0; cyc(30);
    lit("held_through_reset", 8'hC0, 8'h00);
    BTNC = 0; cyc(12);
    BTNC = 1; cyc(10);
    lit("fresh_press", 8'hC0, 8'h40);
    BTNC = 0; cyc(10);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0: begin SW = 2'($urandom); cyc($urandom_range(1, 5)); end
        1, 2, 3: begin
          BTNC = 1; cyc($urandom_range(1, 10));
          BTNC = 0; cyc($urandom_range(1, 10));
        end
        4, 5, 6: begin
          BTNU = 1; cyc($urandom_range(1, 10));
          BTNU = 0; cyc($urandom_range(1, 10));
        end
        7: begin
          BTNC = 1; BTNU = 1; cyc($urandom_range(1, 10));
          BTNC = 0; BTNU = 0; cyc($urandom_range(1, 10));
        end
        8: cyc($urandom_range(1, 20));
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            BTNC = 1'($urandom); BTNU = 1'($urandom);
            rst = 1; cyc($urandom_range(1, 3));
            rst = 0; cyc($urandom_range(1, 10));
            BTNC = 0; BTNU = 0;
          end
          cyc(1);
        end
      endcase
    end
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
